load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory stage fed by the ALU: takes the ALU result as effective address for RV32I loads/stores.
//  Issues a req/ready data-memory transaction, aligns store data into byte lanes, extracts and
//  sign/zero-extends load data. Stalls the single-cycle core (o_busy) until the access completes.
// PARAMETERS
//  (none; fixed 32-bit address/data, 4 byte lanes)
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst_n        in   1   asynchronous reset, active low
//  i_valid        in   1   core presents a memory instruction this cycle
//  i_load         in   1   instruction is a load
//  i_store        in   1   instruction is a store
//  i_funct3       in   3   size/sign: [1:0] 00=B 01=H 1x=W; [2]=1 zero-extend load
//  i_addr         in   32  effective address (ALU result)
//  i_wdata        in   32  store data (rs2)
//  o_busy         out  1   stall core; combinational
//  o_done         out  1   one-cycle completion pulse
//  o_rdata        out  32  extended load result, valid when o_done on a load
//  o_misaligned   out  1   misalignment pulse with o_done (LSU_MISALIGN_TRAP_EN only)
//  o_dmem_req     out  1   memory request
//  i_dmem_ready   in   1   memory accepts request this cycle
//  o_dmem_we      out  1   1=write
//  o_dmem_addr    out  32  word-aligned address ({addr[31:2],2'b00})
//  o_dmem_wdata   out  32  lane-aligned store data
//  o_dmem_mask    out  4   byte-lane write enables (0000 on loads)
//  i_dmem_rvalid  in   1   read data valid
//  i_dmem_rdata   in   32  read word
// BEHAVIOUR
//  Reset: state IDLE; all registered outputs 0; o_busy 0 while i_rst_n low.
//  FSM IDLE->REQ->(WAIT)->DONE->IDLE:
//   IDLE: i_valid&(i_load|i_store) -> capture addr/size/sign/we/lane data, go REQ.
//         i_load&i_store together -> store wins. o_busy=1 in this accept cycle.
//   REQ:  o_dmem_req=1, addr/we/wdata/mask held stable until i_dmem_ready. Handshake: store->DONE,
//         load->WAIT. o_busy=1.
//   WAIT: i_dmem_rvalid -> latch extracted data into o_rdata, go DONE. o_busy=1.
//         rvalid sampled only in WAIT (memory returns >=1 cycle after ready).
//   DONE: o_done=1, o_busy=0, core advances; i_valid ignored; unconditionally -> IDLE.
//  Min latency from accept (T): store o_done at T+2, load o_done at T+3.
//  Store lanes: SB mask=0001<<a[1:0], data=byte x4; SH mask=0011<<{a[1],0}, data=half x2; SW 1111.
//  Load extract: w=rdata>>(8*a[1:0]); B/H sign-extend unless funct3[2]; W passes through.
//  o_rdata holds last load value; stores do not change it.
//  Async reset mid-access: immediately IDLE, o_dmem_req drops, late rvalid ignored.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with a[0]!=0 or W with a[1:0]!=0 -> no memory request;
//   IDLE->DONE, o_done=1 with o_misaligned=1, o_rdata unchanged.
//  Undefined: no o_misaligned port; offending low address bits forced to 0, access proceeds aligned.
// STRUCTURE
//  lsu_pkg: state enum (IDLE,REQ,WAIT,DONE), size encodings (SZ_B/SZ_H/SZ_W), funct3 constants.
//  Sub-module lsu_align (combinational): store mask/data generation and load extract/extend.
// TESTING
//  SW a=0x100 d=0xDEADBEEF, ready at once -> req 1 cycle, mask 1111, wdata DEADBEEF, o_done T+2.
//  SB a=0x103 d=0x000000A5 -> mask 1000, wdata A5A5A5A5, addr 0x100.
//  LB a=0x102, rdata 0x0080FF00 -> o_rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  LH a=0x102, ready delayed 3 cycles, rvalid 2 later -> req held stable, o_busy high throughout,
//   o_rdata=sign-ext rdata[31:16], single o_done pulse.
//  LW a=0x101: with LSU_MISALIGN_TRAP_EN -> no req, o_done+o_misaligned at T+1; without -> addr 0x100.
//  i_rst_n low while in WAIT, rvalid after release -> IDLE, o_done never pulses, o_rdata 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Package for the load/store unit.
// Holds the FSM state encoding, access-size encodings, funct3 constants and
// small helpers that decode funct3 and handle low address bits.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0]: 00=byte, 01=half, 1x=word
  function automatic lsu_size_t size_of(input logic [1:0] f3_lo);
    if (f3_lo[1])      return SZ_W;
    else if (f3_lo[0]) return SZ_H;
    else               return SZ_B;
  endfunction

  // Byte offset actually used for lane selection: bits that would make a
  // half/word access straddle a word are cleared.
  function automatic logic [1:0] align_off(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return off;
      SZ_H:    return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
// Store side: builds the byte-lane write mask and replicates store data so the
//   addressed lanes carry the right bytes.
//   st_size/st_off/st_data in, st_mask/st_lanes out.
// Load side: shifts the returned word down by the byte offset and sign- or
//   zero-extends byte/half results.
//   ld_size/ld_off/ld_unsigned/ld_word in, ld_result out.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lanes,
  input  lsu_size_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_result
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_mask  = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      SZ_B: begin
        st_mask  = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_mask  = 4'b0011 << {st_off[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
      end
      default: begin
        st_mask  = 4'b1111;
        st_lanes = st_data;
      end
    endcase
  end

  always_comb begin
    ld_shifted = ld_word >> {ld_off, 3'b000};
    ld_result  = ld_shifted;
    case (ld_size)
      SZ_B:    ld_result = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_result = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_result = ld_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit sitting in the memory stage of a single-cycle core.
// Takes the ALU result as effective address, runs one data-memory
// transaction, and stalls the core via o_busy until the access completes.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_valid, i_load, i_store       memory instruction presented by the core
//   i_funct3, i_addr, i_wdata      size/sign, effective address, store data
//   o_busy                         combinational stall
//   o_done                         one-cycle completion pulse
//   o_rdata                        extended load result (holds last load)
//   o_misaligned                   trap pulse (only with LSU_MISALIGN_TRAP_EN)
//   o_dmem_*/i_dmem_*              data-memory request/response interface
//   o_dbg_state                    current FSM state for observation
//
// Configuration macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses skip memory and complete with o_misaligned; when undefined the
// offending low address bits are ignored and the access proceeds aligned.
//
// Memory handshake: o_dmem_req is held with stable addr/we/wdata/mask until a
// cycle where i_dmem_ready is high; that cycle transfers the request. For a
// load, i_dmem_rvalid is only looked at after the transfer (WAIT state) and
// is a one-cycle indication that i_dmem_rdata holds the read word.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        o_misaligned,
`endif
  output logic        o_dmem_req,
  input  logic        i_dmem_ready,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output lsu_state_t  o_dbg_state
);

  lsu_state_t  state;
  logic        accept;
  lsu_size_t   size_in;
  logic [1:0]  off_in;
  logic [3:0]  st_mask;
  logic [31:0] st_lanes;
  logic [31:0] ld_result;

  // Captured request
  logic [29:0] word_q;
  logic [1:0]  off_q;
  lsu_size_t   size_q;
  logic        uns_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;

  assign accept  = i_valid & (i_load | i_store);
  assign size_in = size_of(i_funct3[1:0]);
  assign off_in  = align_off(size_in, i_addr[1:0]);

  lsu_align u_align (
    .st_size    (size_in),
    .st_off     (off_in),
    .st_data    (i_wdata),
    .st_mask    (st_mask),
    .st_lanes   (st_lanes),
    .ld_size    (size_q),
    .ld_off     (off_q),
    .ld_unsigned(uns_q),
    .ld_word    (i_dmem_rdata),
    .ld_result  (ld_result)
  );

  // Stall covers the accept cycle too; the core only advances in DONE.
  assign o_busy = i_rst_n & (((state == IDLE) & accept) | (state == REQ) | (state == WAIT));

  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {word_q, 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_mask  = mask_q;
  assign o_dbg_state  = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_done     <= 1'b0;
      o_rdata    <= 32'h0;
      o_dmem_req <= 1'b0;
      word_q     <= 30'h0;
      off_q      <= 2'b00;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      mask_q     <= 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
    end else begin
      o_done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misaligned <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(size_in, i_addr[1:0])) begin
              state        <= DONE;
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
            end else
`endif
            begin
              // Store wins when both load and store are flagged.
              word_q     <= i_addr[31:2];
              off_q      <= off_in;
              size_q     <= size_in;
              uns_q      <= i_funct3[2];
              we_q       <= i_store;
              wdata_q    <= st_lanes;
              mask_q     <= i_store ? st_mask : 4'b0000;
              o_dmem_req <= 1'b1;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (i_dmem_ready) begin
            o_dmem_req <= 1'b0;
            if (we_q) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            o_rdata <= ld_result;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
